// File: rtl/mem_access_pkg.sv
// Shared constants and types for the memory access unit: funct3 encodings,
// requester identity, MMIO addresses and the load/store legality rule.
package mem_access_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] MMIO_LEDS   = 32'hFFFF_FFFC;
  localparam logic [31:0] MMIO_MILLIS = 32'hFFFF_FFF8;
  localparam logic [31:0] MMIO_MICROS = 32'hFFFF_FFF4;

  typedef enum logic {PORT_IF, PORT_LS} port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  is_store;
    logic  fault;
  } inflight_t;

  // funct3[1:0] encodes the access width for every legal load/store.
  function automatic logic ls_access_legal(logic write, logic [2:0] funct3, logic [1:0] offset);
    logic funct3_ok;
    logic align_ok;
    if (write) funct3_ok = funct3 inside {F3_SB, F3_SH, F3_SW};
    else       funct3_ok = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    case (funct3[1:0])
      2'b10:   align_ok = (offset == 2'b00);
      2'b01:   align_ok = !offset[0];
      default: align_ok = 1'b1;
    endcase
    return funct3_ok && align_ok;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// One-grant-per-cycle arbiter: load/store has priority, fetch is forced through
// after MAX_FETCH_STARVE consecutive load/store grants while it waits.
module mem_port_arbiter #(
  parameter int unsigned MAX_FETCH_STARVE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_valid,
  input  logic ls_valid,
  output logic if_grant,
  output logic ls_grant
);

  logic [3:0] starve_cnt;
  logic       force_if;

  // NOTE: every output of a combinational block is assigned on all paths, so no latch is inferred.
  always_comb begin
    force_if = if_valid && (starve_cnt == 4'(MAX_FETCH_STARVE));
    ls_grant = rst_n && ls_valid && !force_if;
    if_grant = rst_n && if_valid && !ls_grant;
  end

  // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (ls_grant && if_valid) begin
      if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory bus initiator for the fetch and load/store clients: legality check,
// request mux onto the single memory port and routing of 1-cycle read results.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MAX_FETCH_STARVE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  output logic        if_resp_fault,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_req_write,
  input  logic [2:0]  ls_req_funct3,
  input  logic [31:0] ls_req_addr,
  input  logic [31:0] ls_req_wdata,
  output logic        ls_resp_valid,
  output logic [31:0] ls_resp_rdata,
  output logic        ls_resp_fault,
  output logic        mem_write_mem,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);

  logic      if_grant;
  logic      ls_grant;
  logic      if_legal;
  logic      ls_legal;
  logic      is_if;
  logic      is_ls;
  logic [31:0] resp_data;
  inflight_t inflight_d;
  inflight_t inflight_q;

  mem_port_arbiter #(.MAX_FETCH_STARVE(MAX_FETCH_STARVE)) u_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .if_grant (if_grant),
    .ls_grant (ls_grant)
  );

  assign if_req_ready = if_grant;
  assign ls_req_ready = ls_grant;

  // A faulted grant still books a response slot but leaves the memory port idle.
  always_comb begin
    if_legal          = (if_addr[1:0] == 2'b00);
    ls_legal          = ls_access_legal(ls_req_write, ls_req_funct3, ls_req_addr[1:0]);
    mem_write_mem     = 1'b0;
    mem_funct3        = F3_LW;
    mem_write_address = '0;
    mem_write_data    = '0;
    mem_read_address  = '0;
    inflight_d        = '{valid: 1'b0, port: PORT_IF, is_store: 1'b0, fault: 1'b0};
    if (if_grant) begin
      inflight_d = '{valid: 1'b1, port: PORT_IF, is_store: 1'b0, fault: !if_legal};
      if (if_legal) mem_read_address = if_addr;
    end else if (ls_grant) begin
      inflight_d = '{valid: 1'b1, port: PORT_LS, is_store: ls_req_write, fault: !ls_legal};
      if (ls_legal) begin
        mem_read_address = ls_req_addr;
        mem_funct3       = ls_req_funct3;
        if (ls_req_write) begin
          mem_write_mem     = 1'b1;
          mem_write_address = ls_req_addr;
          mem_write_data    = ls_req_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= '0;
    else        inflight_q <= inflight_d;
  end

  // The flush acts in the response cycle itself, so it gates the valid combinationally.
  always_comb begin
    is_if     = inflight_q.valid && (inflight_q.port == PORT_IF);
    is_ls     = inflight_q.valid && (inflight_q.port == PORT_LS);
    resp_data = (inflight_q.valid && !inflight_q.fault && !inflight_q.is_store)
                ? mem_read_data : '0;
    if_resp_valid = is_if && !if_flush;
    if_resp_data  = is_if ? resp_data : '0;
    if_resp_fault = is_if && inflight_q.fault;
    ls_resp_valid = is_ls;
    ls_resp_rdata = is_ls ? resp_data : '0;
    ls_resp_fault = is_ls && inflight_q.fault;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a behavioural memory plus a reference model that
// predicts grants, port activity and responses every cycle from the access rules.
module tb_mem_access_unit;

  localparam int          MAX_STARVE = 4;
  localparam logic [31:0] MEM_BYTES  = 32'h400;

  typedef struct packed {
    logic        rn;
    logic        ifv;
    logic [31:0] ia;
    logic        fl;
    logic        lv;
    logic        lw;
    logic [2:0]  f3;
    logic [31:0] la;
    logic [31:0] wd;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready, if_flush = 1'b0;
  logic [31:0] if_addr = '0, if_resp_data;
  logic        if_resp_valid, if_resp_fault;
  logic        ls_req_valid = 1'b0, ls_req_ready, ls_req_write = 1'b0;
  logic [2:0]  ls_req_funct3 = 3'b010;
  logic [31:0] ls_req_addr = '0, ls_req_wdata = '0, ls_resp_rdata;
  logic        ls_resp_valid, ls_resp_fault;
  logic        mem_write_mem;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address, mem_write_data, mem_read_address;
  logic [31:0] mem_read_data = '0;

  logic [31:0] env_mem [256] = '{default: 32'h0};
  logic [31:0] mdl_mem [256] = '{default: 32'h0};

  int n_total = 0;
  int n_pass  = 0;

  // Model state: one expected response slot and the fetch-wait counter.
  logic        pend_valid = 1'b0, pend_is_if = 1'b0, pend_fault = 1'b0;
  logic [31:0] pend_data = '0;
  int          starve = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MAX_FETCH_STARVE(MAX_STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .if_resp_fault(if_resp_fault),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_write(ls_req_write),
    .ls_req_funct3(ls_req_funct3), .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
    .ls_resp_valid(ls_resp_valid), .ls_resp_rdata(ls_resp_rdata), .ls_resp_fault(ls_resp_fault),
    .mem_write_mem(mem_write_mem), .mem_funct3(mem_funct3),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
  );

  function automatic logic [31:0] load_extract(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * int'(off)));
    h = 16'(w >> (16 * int'(off[1])));
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(logic [31:0] old, logic [31:0] wdata,
                                              logic [2:0] f3, logic [1:0] off);
    logic [31:0] m, d;
    case (f3[1:0])
      2'b00: begin m = 32'hFF << (8 * int'(off));      d = (wdata & 32'hFF) << (8 * int'(off)); end
      2'b01: begin m = 32'hFFFF << (16 * int'(off[1])); d = (wdata & 32'hFFFF) << (16 * int'(off[1])); end
      default: begin m = 32'hFFFF_FFFF; d = wdata; end
    endcase
    return (old & ~m) | (d & m);
  endfunction

  // Byte count of an access, 0 when the funct3 is not a legal load/store.
  function automatic int unsigned access_size(logic write, logic [2:0] f3);
    case (f3)
      3'b000: return 1;
      3'b001: return 2;
      3'b010: return 4;
      3'b100, 3'b101: return write ? 0 : (f3 == 3'b100 ? 1 : 2);
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] mdl_read(logic [31:0] a, logic [2:0] f3);
    if (a >= MEM_BYTES) return '0;
    return load_extract(mdl_mem[a[9:2]], f3, a[1:0]);
  endfunction

  // Memory environment: commits writes at the edge, returns read data one cycle later.
  always @(posedge clk) begin
    if (mem_write_mem && mem_write_address < MEM_BYTES)
      env_mem[mem_write_address[9:2]] = store_merge(env_mem[mem_write_address[9:2]],
                                                    mem_write_data, mem_funct3,
                                                    mem_write_address[1:0]);
    if (mem_read_address < MEM_BYTES)
      mem_read_data <= load_extract(env_mem[mem_read_address[9:2]], mem_funct3,
                                    mem_read_address[1:0]);
    else
      mem_read_data <= '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle: drive at the falling edge, compare everything, advance the model.
  task automatic do_cycle(input stim_t s);
    logic        g_if, g_ls, legal, e_we, e_ifv, e_lsv;
    logic [2:0]  e_f3;
    logic [31:0] e_ra, e_wa, e_wd, e_rd;
    int unsigned sz;
    @(negedge clk);
    rst_n = s.rn;
    if_req_valid = s.ifv; if_addr = s.ia; if_flush = s.fl;
    ls_req_valid = s.lv; ls_req_write = s.lw; ls_req_funct3 = s.f3;
    ls_req_addr = s.la; ls_req_wdata = s.wd;
    #1;
    if (!s.rn) begin
      pend_valid = 1'b0;
      starve = 0;
    end

    e_ifv = pend_valid && pend_is_if && !s.fl;
    e_lsv = pend_valid && !pend_is_if;
    check("if_resp_valid", 32'(if_resp_valid), 32'(e_ifv));
    check("ls_resp_valid", 32'(ls_resp_valid), 32'(e_lsv));
    if (e_ifv) begin
      check("if_resp_data", if_resp_data, pend_data);
      check("if_resp_fault", 32'(if_resp_fault), 32'(pend_fault));
    end
    if (e_lsv) begin
      check("ls_resp_rdata", ls_resp_rdata, pend_data);
      check("ls_resp_fault", 32'(ls_resp_fault), 32'(pend_fault));
    end

    g_ls = s.rn && s.lv && !(s.ifv && starve == MAX_STARVE);
    g_if = s.rn && s.ifv && !g_ls;
    check("if_req_ready", 32'(if_req_ready), 32'(g_if));
    check("ls_req_ready", 32'(ls_req_ready), 32'(g_ls));

    legal = 1'b0; e_we = 1'b0; e_f3 = 3'b010;
    e_ra = '0; e_wa = '0; e_wd = '0; e_rd = '0;
    if (g_if) begin
      legal = (s.ia % 4 == 0);
      if (legal) begin
        e_ra = s.ia;
        e_rd = mdl_read(s.ia, 3'b010);
      end
    end else if (g_ls) begin
      sz = access_size(s.lw, s.f3);
      legal = (sz != 0) && (s.la % sz == 0);
      if (legal) begin
        e_ra = s.la;
        e_f3 = s.f3;
        if (s.lw) begin
          e_we = 1'b1; e_wa = s.la; e_wd = s.wd;
        end else begin
          e_rd = mdl_read(s.la, s.f3);
        end
      end
    end
    check("mem_write_mem", 32'(mem_write_mem), 32'(e_we));
    check("mem_funct3", 32'(mem_funct3), 32'(e_f3));
    check("mem_read_address", mem_read_address, e_ra);
    check("mem_write_address", mem_write_address, e_wa);
    check("mem_write_data", mem_write_data, e_wd);

    pend_valid = g_if || g_ls;
    pend_is_if = g_if;
    pend_fault = !legal;
    pend_data  = e_rd;
    if (e_we && s.la < MEM_BYTES)
      mdl_mem[s.la[9:2]] = store_merge(mdl_mem[s.la[9:2]], s.wd, s.f3, s.la[1:0]);
    if (g_ls && s.ifv) starve = (starve == 15) ? 15 : starve + 1;
    else               starve = 0;
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s = '0;
    s.rn = 1'b1;
    s.f3 = 3'b010;
    return s;
  endfunction

  function automatic stim_t ls_s(logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    stim_t s;
    s = idle_s();
    s.lv = 1'b1; s.lw = w; s.f3 = f3; s.la = a; s.wd = d;
    return s;
  endfunction

  function automatic stim_t if_s(logic [31:0] a, logic fl);
    stim_t s;
    s = idle_s();
    s.ifv = 1'b1; s.ia = a; s.fl = fl;
    return s;
  endfunction

  task automatic grant_pattern(input string name);
    stim_t s;
    logic [5:0] seen;
    do_cycle(idle_s());
    for (int i = 0; i < 6; i++) begin
      s = ls_s(1'b0, 3'b010, 32'h200 + 32'(4 * i), '0);
      s.ifv = 1'b1;
      s.ia  = 32'h80 + 32'(4 * i);
      do_cycle(s);
      seen[5 - i] = ls_req_ready;
    end
    check(name, 32'(seen), 32'b111101);
  endtask

  initial begin
    stim_t s;
    // Reset state
    s = if_s(32'h10, 1'b0);
    s.rn = 1'b0;
    s.lv = 1'b1;
    do_cycle(s);
    check("reset_if_ready", 32'(if_req_ready), 32'h0);
    check("reset_ls_ready", 32'(ls_req_ready), 32'h0);
    check("reset_ls_resp", 32'(ls_resp_valid), 32'h0);
    do_cycle(s);

    // Store then load of the same word on consecutive cycles
    do_cycle(ls_s(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF));
    do_cycle(ls_s(1'b0, 3'b010, 32'h100, '0));
    do_cycle(idle_s());
    check("sw_lw_forward", ls_resp_rdata, 32'hDEAD_BEEF);

    // Signed half and unsigned byte from 0x8001_0000
    do_cycle(ls_s(1'b1, 3'b010, 32'h100, 32'h8001_0000));
    do_cycle(ls_s(1'b0, 3'b001, 32'h102, '0));
    do_cycle(ls_s(1'b0, 3'b100, 32'h103, '0));
    check("lh_sign", ls_resp_rdata, 32'hFFFF_8001);
    do_cycle(idle_s());
    check("lbu_zero", ls_resp_rdata, 32'h0000_0080);

    // Faults: misaligned word, misaligned half store, illegal funct3
    do_cycle(ls_s(1'b0, 3'b010, 32'h101, '0));
    do_cycle(ls_s(1'b1, 3'b001, 32'h003, 32'h1234));
    check("lw_misaligned_fault", 32'(ls_resp_fault), 32'h1);
    check("sh_no_strobe", 32'(mem_write_mem), 32'h0);
    do_cycle(ls_s(1'b0, 3'b011, 32'h100, '0));
    check("sh_misaligned_fault", 32'(ls_resp_fault), 32'h1);
    do_cycle(idle_s());
    check("funct3_011_fault", 32'(ls_resp_fault), 32'h1);
    check("fault_rdata_zero", ls_resp_rdata, 32'h0);

    // Fetch starvation limit
    grant_pattern("grant_order");

    // Flush drops the older fetch, the newer one still answers
    do_cycle(idle_s());
    do_cycle(if_s(32'h40, 1'b0));
    do_cycle(if_s(32'h44, 1'b1));
    check("flush_suppress", 32'(if_resp_valid), 32'h0);
    do_cycle(idle_s());
    check("after_flush_resp", 32'(if_resp_valid), 32'h1);

    // Reset while a load is in flight
    do_cycle(ls_s(1'b0, 3'b010, 32'h100, '0));
    s = ls_s(1'b0, 3'b010, 32'h104, '0);
    s.rn = 1'b0;
    do_cycle(s);
    check("reset_kills_resp", 32'(ls_resp_valid), 32'h0);
    do_cycle(s);
    do_cycle(idle_s());
    check("no_resp_after_reset", 32'(ls_resp_valid), 32'h0);
    grant_pattern("grant_order_after_reset");

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      s = idle_s();
      s.rn  = ($urandom_range(0, 99) != 0);
      s.ifv = ($urandom_range(0, 9) < 7);
      s.ia  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 9) == 0) s.ia[1:0] = 2'($urandom_range(1, 3));
      s.fl  = ($urandom_range(0, 99) < 15);
      s.lv  = ($urandom_range(0, 9) < 6);
      s.lw  = $urandom_range(0, 1) == 1;
      s.f3  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                          : (s.lw ? 3'($urandom_range(0, 2))
                                                  : 3'($urandom_range(0, 5) == 3 ? 4 : $urandom_range(0, 5)));
      s.la  = ($urandom_range(0, 19) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : 32'($urandom_range(0, 32'h3FF));
      if ($urandom_range(0, 1) == 1) s.la = s.la & ~32'(access_size(1'b0, s.f3) - 1);
      s.wd  = $urandom;
      do_cycle(s);
    end
    do_cycle(idle_s());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
